// File: rtl/key_counter_bank.sv
// -----------------------------------------------------------------------------
// key_counter_bank
//
// A bank of N_CH independent up/down counters. Each counter is driven by its
// own pair of raw, active-low keys (increment and decrement). Every key goes
// through a 2-flop synchroniser, then a debouncer, then a press detector. The
// counters either wrap modulo MAX_VALUE+1 or saturate at 0 / MAX_VALUE.
//
// Parameters:
//   N_CH            number of channels
//   WIDTH           bits per counter
//   MAX_VALUE       highest count value (1 .. 2**WIDTH-1)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a key change (>= 1)
//   SATURATE        0 = wrap-around, 1 = saturate at the limits
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   inc_n  raw increment keys, active-low, bit i -> channel i
//   dec_n  raw decrement keys, active-low, bit i -> channel i
//   clear  synchronous clear of all counters, active-high
//   cnt    counter values, channel i at cnt[i*WIDTH +: WIDTH]
//   wrap   one-cycle pulse when channel i wraps in either direction
// -----------------------------------------------------------------------------
module key_counter_bank #(
    parameter int N_CH            = 4,
    parameter int WIDTH           = 4,
    parameter int MAX_VALUE       = 2**WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SATURATE        = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         inc_n,
    input  logic [N_CH-1:0]         dec_n,
    input  logic                    clear,
    output logic [N_CH*WIDTH-1:0]   cnt,
    output logic [N_CH-1:0]         wrap
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DC_W-1:0]  DC_LAST   = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VALUE);
    localparam bit               WRAP_MODE = (SATURATE == 0);
    localparam int               N_KEY     = 2 * N_CH;

    // Keys 0..N_CH-1 are the increment keys, N_CH..2*N_CH-1 the decrement keys.
    logic [N_KEY-1:0] key_raw;
    logic [N_KEY-1:0] press;

    assign key_raw = {dec_n, inc_n};

    // -------------------------------------------------------------------------
    // Per-key conditioning: synchroniser, debouncer, press detector
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_KEY; gi++) begin : g_key
        logic            s1_q;
        logic            s2_q;
        logic            db_q;
        logic            db_d;
        logic [DC_W-1:0] dc_q;
        logic [DC_W-1:0] dc_d;
        logic            press_q;
        logic            press_d;

        always_comb begin
            db_d = db_q;
            dc_d = dc_q;
            if (s2_q == db_q) begin
                // Input agrees with the accepted state: any partial count
                // from a bounce is thrown away.
                dc_d = '0;
            end else if (dc_q == DC_LAST) begin
                db_d = s2_q;
                dc_d = '0;
            end else begin
                dc_d = dc_q + DC_W'(1);
            end
            // Press is the accepted 1->0 transition. It is taken from the
            // next-state value so that the event is registered in the same
            // edge that updates db, keeping latency at 3+DEBOUNCE_CYCLES.
            press_d = db_q & ~db_d;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q    <= 1'b1;
                s2_q    <= 1'b1;
                db_q    <= 1'b1;
                dc_q    <= '0;
                press_q <= 1'b0;
            end else begin
                s1_q    <= key_raw[gi];
                s2_q    <= s1_q;
                db_q    <= db_d;
                dc_q    <= dc_d;
                press_q <= press_d;
            end
        end

        assign press[gi] = press_q;
    end

    // -------------------------------------------------------------------------
    // Per-channel counters
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic             wrap_q;
        logic             wrap_d;
        logic             inc_ev;
        logic             dec_ev;

        assign inc_ev = press[gi];
        assign dec_ev = press[N_CH + gi];

        always_comb begin
            cnt_d  = cnt_q;
            wrap_d = 1'b0;
            if (clear) begin
                cnt_d = '0;
            end else if (inc_ev && dec_ev) begin
                // Opposing presses in the same cycle cancel out.
                cnt_d = cnt_q;
            end else if (inc_ev) begin
                if (cnt_q < MAX_CNT) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else if (WRAP_MODE) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else if (dec_ev) begin
                if (cnt_q > '0) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else if (WRAP_MODE) begin
                    cnt_d  = MAX_CNT;
                    wrap_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                wrap_q <= wrap_d;
            end
        end

        assign cnt[gi*WIDTH +: WIDTH] = cnt_q;
        assign wrap[gi]               = wrap_q;
    end

endmodule

// File: tb/tb_key_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_key_counter_bank
//
// Drives the same key stimulus into two instances: one in wrap mode with
// MAX_VALUE=9 and one in saturate mode with the default MAX_VALUE=15. Expected
// counts and wrap flags come from a small arithmetic model and are queued when
// a press is driven, then popped and compared when the DUT result is due.
// -----------------------------------------------------------------------------
module tb_key_counter_bank;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int D    = 4;
    localparam int MAXW = 9;
    localparam int MAXS = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   inc_n = '1;
    logic [N-1:0]   dec_n = '1;
    logic           clear = 1'b0;
    logic [N*W-1:0] cnt_w;
    logic [N*W-1:0] cnt_s;
    logic [N-1:0]   wrap_w;
    logic [N-1:0]   wrap_s;

    int checks = 0;
    int errors = 0;

    int ew [N];          // model count, wrap instance
    int es [N];          // model count, saturate instance
    int ew_wraps [N];    // model wrap pulses, wrap instance
    int mon_w [N];       // observed wrap-high cycles, wrap instance
    int mon_s [N];       // observed wrap-high cycles, saturate instance

    typedef struct {
        int ch;
        int cw;
        int cs;
        int ww;
        int ws;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    key_counter_bank #(
        .N_CH(N), .WIDTH(W), .MAX_VALUE(MAXW), .DEBOUNCE_CYCLES(D), .SATURATE(0)
    ) u_wrap (
        .clk(clk), .reset(reset), .inc_n(inc_n), .dec_n(dec_n),
        .clear(clear), .cnt(cnt_w), .wrap(wrap_w)
    );

    key_counter_bank #(
        .N_CH(N), .WIDTH(W), .DEBOUNCE_CYCLES(D), .SATURATE(1)
    ) u_sat (
        .clk(clk), .reset(reset), .inc_n(inc_n), .dec_n(dec_n),
        .clear(clear), .cnt(cnt_s), .wrap(wrap_s)
    );

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < N; c++) begin
                if (wrap_w[c] !== 1'b0) mon_w[c]++;
                if (wrap_s[c] !== 1'b0) mon_s[c]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Arithmetic model of one accepted press on one channel.
    task automatic model(input int ch, input bit is_dec, output int ww, output int ws);
        ww = 0;
        ws = 0;
        if (!is_dec) begin
            if (ew[ch] < MAXW) ew[ch]++; else begin ew[ch] = 0; ww = 1; end
            if (es[ch] < MAXS) es[ch]++;
        end else begin
            if (ew[ch] > 0) ew[ch]--; else begin ew[ch] = MAXW; ww = 1; end
            if (es[ch] > 0) es[ch]--;
        end
        ew_wraps[ch] += ww;
    endtask

    task automatic clear_model();
        for (int c = 0; c < N; c++) begin
            ew[c] = 0;
            es[c] = 0;
        end
    endtask

    // One full press/release of a key; result checked at the exact latency.
    task automatic press(input string tag, input int ch, input bit is_dec);
        exp_t e;
        int   ww;
        int   ws;
        model(ch, is_dec, ww, ws);
        e.ch = ch; e.cw = ew[ch]; e.cs = es[ch]; e.ww = ww; e.ws = ws;
        sb.push_back(e);
        if (is_dec) dec_n[ch] = 1'b0; else inc_n[ch] = 1'b0;
        tick(3 + D);
        e = sb.pop_front();
        chk({tag, " cnt_w"},  32'(cnt_w[e.ch*W +: W]), 32'(e.cw));
        chk({tag, " cnt_s"},  32'(cnt_s[e.ch*W +: W]), 32'(e.cs));
        chk({tag, " wrap_w"}, 32'(wrap_w[e.ch]), 32'(e.ww));
        chk({tag, " wrap_s"}, 32'(wrap_s[e.ch]), 32'(e.ws));
        $display("press %s ch=%0d dec=%0d cnt_w=%0d cnt_s=%0d wrap_w=%0d",
                 tag, ch, is_dec, cnt_w[ch*W +: W], cnt_s[ch*W +: W], wrap_w[ch]);
        tick(1);
        chk({tag, " wrap_w one-cycle"}, 32'(wrap_w[ch]), 32'd0);
        if (is_dec) dec_n[ch] = 1'b1; else inc_n[ch] = 1'b1;
        tick(2 * D);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            ew[c] = 0; es[c] = 0; ew_wraps[c] = 0; mon_w[c] = 0; mon_s[c] = 0;
        end

        // Reset state
        tick(3);
        reset = 1'b0;
        for (int c = 0; c < N; c++) begin
            chk("reset cnt_w", 32'(cnt_w[c*W +: W]), 32'd0);
            chk("reset cnt_s", 32'(cnt_s[c*W +: W]), 32'd0);
        end
        chk("reset wrap_w", 32'(wrap_w), 32'd0);
        chk("reset wrap_s", 32'(wrap_s), 32'd0);

        // Single press: cnt0 changes exactly 3+D edges after the key edge
        inc_n[0] = 1'b0;
        tick(2 + D);
        chk("latency early cnt0", 32'(cnt_w[0 +: W]), 32'd0);
        tick(1);
        ew[0] = 1; es[0] = 1;
        chk("latency cnt0_w", 32'(cnt_w[0 +: W]), 32'd1);
        chk("latency cnt0_s", 32'(cnt_s[0 +: W]), 32'd1);
        chk("latency others", 32'(cnt_w[N*W-1:W]), 32'd0);
        tick(12);
        chk("held no repeat", 32'(cnt_w[0 +: W]), 32'd1);
        $display("single press cnt0=%0d after hold", cnt_w[0 +: W]);
        inc_n[0] = 1'b1;
        tick(2 * D);

        // Bounce rejection on channel 1
        for (int i = 0; i < 5; i++) begin
            inc_n[1] = 1'b0; tick(2);
            inc_n[1] = 1'b1; tick(2);
        end
        tick(2 * D);
        chk("bounce cnt1_w", 32'(cnt_w[W +: W]), 32'd0);
        chk("bounce cnt1_s", 32'(cnt_s[W +: W]), 32'd0);
        inc_n[1] = 1'b0;
        tick(10);
        ew[1] = 1; es[1] = 1;
        chk("stable cnt1_w", 32'(cnt_w[W +: W]), 32'd1);
        chk("stable cnt1_s", 32'(cnt_s[W +: W]), 32'd1);
        $display("bounce test cnt1=%0d", cnt_w[W +: W]);
        inc_n[1] = 1'b1;
        tick(2 * D);

        // Wrap mode: 10 increments then one decrement on channel 2
        for (int i = 0; i < 10; i++) press("inc2", 2, 1'b0);
        chk("wrap pulses after 9->0", 32'(mon_w[2]), 32'd1);
        press("dec2 from 0", 2, 1'b1);
        chk("wrap pulses after 0->9", 32'(mon_w[2]), 32'd2);

        // Clear, then saturate checks on channel 2
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        clear_model();
        for (int c = 0; c < N; c++) begin
            chk("clear cnt_w", 32'(cnt_w[c*W +: W]), 32'd0);
            chk("clear cnt_s", 32'(cnt_s[c*W +: W]), 32'd0);
        end
        $display("clear all cnt_w=%h cnt_s=%h", cnt_w, cnt_s);
        for (int i = 0; i < 17; i++) press("sat inc2", 2, 1'b0);
        chk("saturate top", 32'(cnt_s[2*W +: W]), 32'd15);
        for (int i = 0; i < 20; i++) press("sat dec2", 2, 1'b1);
        chk("saturate bottom", 32'(cnt_s[2*W +: W]), 32'd0);

        // Simultaneous inc and dec on channel 3 at count 5
        for (int i = 0; i < 5; i++) press("inc3", 3, 1'b0);
        inc_n[3] = 1'b0;
        dec_n[3] = 1'b0;
        tick(4 + D);
        chk("simul cnt3_w", 32'(cnt_w[3*W +: W]), 32'd5);
        chk("simul cnt3_s", 32'(cnt_s[3*W +: W]), 32'd5);
        chk("simul wrap3", 32'(wrap_w[3]), 32'd0);
        $display("simultaneous cnt3=%0d", cnt_w[3*W +: W]);
        inc_n[3] = 1'b1;
        dec_n[3] = 1'b1;
        tick(2 * D);

        // Clear colliding with an increment event on channel 0 at count 4
        for (int i = 0; i < 4; i++) press("inc0", 0, 1'b0);
        inc_n[0] = 1'b0;
        tick(2 + D);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        clear_model();
        chk("clear wins cnt0_w", 32'(cnt_w[0 +: W]), 32'd0);
        chk("clear wins cnt0_s", 32'(cnt_s[0 +: W]), 32'd0);
        chk("clear wins cnt3", 32'(cnt_w[3*W +: W]), 32'd0);
        tick(10);
        chk("no late inc cnt0", 32'(cnt_w[0 +: W]), 32'd0);
        $display("clear collision cnt0=%0d", cnt_w[0 +: W]);
        inc_n[0] = 1'b1;
        tick(2 * D);

        // Reset in the middle of a debounce on dec_n[0]
        dec_n[0] = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_model();
        tick(2 + D);
        chk("rst mid early cnt0", 32'(cnt_w[0 +: W]), 32'd0);
        tick(1);
        chk("rst mid cnt0_w", 32'(cnt_w[0 +: W]), 32'(MAXW));
        chk("rst mid wrap0_w", 32'(wrap_w[0]), 32'd1);
        chk("rst mid cnt0_s", 32'(cnt_s[0 +: W]), 32'd0);
        ew_wraps[0]++;
        $display("reset mid-debounce cnt0=%0d", cnt_w[0 +: W]);
        dec_n[0] = 1'b1;
        tick(2 * D);

        // Wrap pulse totals
        for (int c = 0; c < N; c++) begin
            chk("wrap_w total", 32'(mon_w[c]), 32'(ew_wraps[c]));
            chk("wrap_s never", 32'(mon_s[c]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
